// File: rtl/ram_block_sweep_if.sv
// User-side bus of the swept scratch RAM: write port, read port, clear request and status.
interface ram_block_sweep_if #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 8,
    parameter int BYTE_WIDTH    = 8
);
    localparam int NB = RAM_WIDTH / BYTE_WIDTH;

    logic                     we;
    logic [NB-1:0]            be;
    logic [RAM_ADDR_BITS-1:0] wa;
    logic [RAM_WIDTH-1:0]     data_in;
    logic                     re;
    logic [RAM_ADDR_BITS-1:0] ra;
    logic                     clear;
    logic [RAM_WIDTH-1:0]     data_out;
    logic                     rvalid;
    logic                     busy;

    modport master (
        output we, be, wa, data_in, re, ra, clear,
        input  data_out, rvalid, busy
    );

    modport slave (
        input  we, be, wa, data_in, re, ra, clear,
        output data_out, rvalid, busy
    );
endinterface

// File: rtl/ram_block_sweep.sv
// Simple dual-port RAM with byte enables, registered read, selectable read-during-write,
// and a clear engine that sweeps every word to CLEAR_VALUE after reset or on request.
module ram_block_sweep #(
    parameter int                   RAM_WIDTH     = 32,
    parameter int                   RAM_ADDR_BITS = 8,
    parameter int                   BYTE_WIDTH    = 8,
    parameter bit                   RDW_MODE      = 1'b0,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input logic              clk,
    input logic              rst_n,
    ram_block_sweep_if.slave bus
);
    localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

    generate
        if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
            $error("RAM_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic {SWEEP, READY} state_t;

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] ptr;
    logic                     busy_q;
    logic                     rvalid_q;
    logic [RAM_WIDTH-1:0]     data_out_q;
    logic [RAM_WIDTH-1:0]     mem [DEPTH];

    logic                     user_ok;
    logic [NB-1:0]            wr_lanes;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [RAM_WIDTH-1:0]     wr_data;
    logic [RAM_WIDTH-1:0]     old_word;
    logic [RAM_WIDTH-1:0]     merged_word;

    // A clear request in READY pre-empts any user access sampled on the same edge.
    assign user_ok = (state == READY) && !bus.clear;

    always_comb begin
        wr_lanes = '0;
        wr_addr  = ptr;
        wr_data  = CLEAR_VALUE;
        if (state == SWEEP) begin
            wr_lanes = '1;
        end else if (user_ok && bus.we) begin
            wr_lanes = bus.be;
            wr_addr  = bus.wa;
            wr_data  = bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Merged word is what the array will hold after this edge's user write completes.
    always_comb begin
        old_word    = mem[bus.ra];
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.we && (bus.wa == bus.ra) && bus.be[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SWEEP;
            ptr        <= '0;
            busy_q     <= 1'b1;
            rvalid_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                READY: begin
                    if (bus.clear) begin
                        ptr    <= '0;
                        state  <= SWEEP;
                        busy_q <= 1'b1;
                    end else if (bus.re) begin
                        rvalid_q   <= 1'b1;
                        data_out_q <= RDW_MODE ? merged_word : old_word;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_ram_block_sweep.sv
// Bench for ram_block_sweep: a default 256x32 old-data instance and a 16x32, 16-bit-lane
// new-data instance with a non-zero clear word, checked through a timestamped read scoreboard.
module tb_ram_block_sweep;
    localparam logic [31:0] CV1 = 32'h5A5A_A5A5;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   n0, n1;
    exp_t q0[$];
    exp_t q1[$];

    ram_block_sweep_if #(.RAM_WIDTH(32), .RAM_ADDR_BITS(8), .BYTE_WIDTH(8))  bus0 ();
    ram_block_sweep_if #(.RAM_WIDTH(32), .RAM_ADDR_BITS(4), .BYTE_WIDTH(16)) bus1 ();

    ram_block_sweep #(
        .RAM_WIDTH(32), .RAM_ADDR_BITS(8), .BYTE_WIDTH(8),
        .RDW_MODE(1'b0), .CLEAR_VALUE(32'h0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    ram_block_sweep #(
        .RAM_WIDTH(32), .RAM_ADDR_BITS(4), .BYTE_WIDTH(16),
        .RDW_MODE(1'b1), .CLEAR_VALUE(CV1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus0.we = 1'b0; bus0.be = '0; bus0.wa = '0; bus0.data_in = '0;
        bus0.re = 1'b0; bus0.ra = '0; bus0.clear = 1'b0;
        bus1.we = 1'b0; bus1.be = '0; bus1.wa = '0; bus1.data_in = '0;
        bus1.re = 1'b0; bus1.ra = '0; bus1.clear = 1'b0;
    endtask

    // Drives one cycle on one instance; a pushed read is due at the negedge after the sampling edge.
    task automatic apply_stimulus(input int sel, input logic we, input logic [3:0] be,
                                  input logic [7:0] wa, input logic [31:0] din,
                                  input logic re, input logic [7:0] ra, input logic clr,
                                  input logic push, input logic [31:0] exp);
        exp_t e;
        e.data = exp;
        e.cyc  = cyc + 1;
        if (sel == 0) begin
            bus0.we = we; bus0.be = be; bus0.wa = wa; bus0.data_in = din;
            bus0.re = re; bus0.ra = ra; bus0.clear = clr;
            if (push) q0.push_back(e);
        end else begin
            bus1.we = we; bus1.be = be[1:0]; bus1.wa = wa[3:0]; bus1.data_in = din;
            bus1.re = re; bus1.ra = ra[3:0]; bus1.clear = clr;
            if (push) q1.push_back(e);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wr(input int sel, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        apply_stimulus(sel, 1'b1, be, a, d, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input int sel, input logic [7:0] a, input logic [31:0] exp);
        apply_stimulus(sel, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, a, 1'b0, 1'b1, exp);
    endtask

    task automatic pulse_clear(input bit with_access);
        bus0.clear = 1'b1;
        bus1.clear = 1'b1;
        if (with_access) begin
            bus0.we = 1'b1; bus0.be = 4'hF; bus0.wa = 8'h05; bus0.data_in = 32'h1234_5678;
            bus0.re = 1'b1; bus0.ra = 8'h05;
            bus1.we = 1'b1; bus1.be = 2'h3; bus1.wa = 4'h5; bus1.data_in = 32'h1234_5678;
            bus1.re = 1'b1; bus1.ra = 4'h5;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts busy cycles on both instances, optionally injecting clear/accesses mid-sweep.
    task automatic measure_busy(input int inject_at, input bit do_clear, input bit do_access,
                                output int c0, output int c1);
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 600 && !(d0 && d1); i++) begin
            @(negedge clk);
            if (!d0) begin
                if (bus0.busy) c0++;
                else d0 = 1'b1;
            end
            if (!d1) begin
                if (bus1.busy) c1++;
                else d1 = 1'b1;
            end
            if (i == inject_at) begin
                if (do_clear) begin
                    bus0.clear = 1'b1;
                    bus1.clear = 1'b1;
                end
                if (do_access) begin
                    bus0.we = 1'b1; bus0.be = 4'hF; bus0.wa = 8'h05; bus0.data_in = 32'h0BAD_F00D;
                    bus0.re = 1'b1; bus0.ra = 8'h05;
                    bus1.we = 1'b1; bus1.be = 2'h3; bus1.wa = 4'h5; bus1.data_in = 32'h0BAD_F00D;
                    bus1.re = 1'b1; bus1.ra = 4'h5;
                end
            end else if (i == inject_at + 1) begin
                idle_inputs();
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_hold(input int sel, input logic [31:0] exp);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        if (sel == 0) begin
            check_output("hold_data0", bus0.data_out, exp);
            check_output("hold_rvalid0", bus0.rvalid, 1'b0);
        end else begin
            check_output("hold_data1", bus1.data_out, exp);
            check_output("hold_rvalid1", bus1.rvalid, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_data0"},   bus0.data_out, 32'h0);
        check_output({tag, "_rvalid0"}, bus0.rvalid,   1'b0);
        check_output({tag, "_busy0"},   bus0.busy,     1'b1);
        check_output({tag, "_data1"},   bus1.data_out, 32'h0);
        check_output({tag, "_rvalid1"}, bus1.rvalid,   1'b0);
        check_output({tag, "_busy1"},   bus1.busy,     1'b1);
    endtask

    task automatic scoreboard(input int sel, input logic rv, input logic [31:0] dout);
        exp_t e;
        if (rv) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                check_output($sformatf("rvalid_spurious%0d", sel), 1'b1, 1'b0);
            end else begin
                if (sel == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check_output($sformatf("read_cycle%0d", sel), cyc, e.cyc);
                check_output($sformatf("read_data%0d", sel), dout, e.data);
            end
        end
        if (sel == 0) begin
            while (q0.size() > 0 && q0[0].cyc <= cyc) begin
                check_output("rvalid_missing0", 1'b0, 1'b1);
                void'(q0.pop_front());
            end
        end else begin
            while (q1.size() > 0 && q1[0].cyc <= cyc) begin
                check_output("rvalid_missing1", 1'b0, 1'b1);
                void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            scoreboard(0, bus0.rvalid, bus0.data_out);
            scoreboard(1, bus1.rvalid, bus1.data_out);
        end
    end

    initial begin
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        measure_busy(6, 1'b1, 1'b1, n0, n1);
        check_output("sweep_len0", n0, 256);
        check_output("sweep_len1", n1, 16);

        rd(0, 8'h00, 32'h0); rd(0, 8'h7F, 32'h0); rd(0, 8'hFF, 32'h0); rd(0, 8'h05, 32'h0);
        rd(1, 8'h00, CV1);   rd(1, 8'h07, CV1);   rd(1, 8'h0F, CV1);   rd(1, 8'h05, CV1);

        wr(0, 8'h10, 32'h1122_3344, 4'hF);
        wr(0, 8'h10, 32'hAABB_CCDD, 4'b0101);
        rd(0, 8'h10, 32'h11BB_33DD);
        check_hold(0, 32'h11BB_33DD);
        wr(0, 8'h10, 32'hFFFF_FFFF, 4'h0);
        rd(0, 8'h10, 32'h11BB_33DD);
        wr(1, 8'h0A, 32'h1122_3344, 4'h3);
        wr(1, 8'h0A, 32'hAABB_CCDD, 4'h1);
        rd(1, 8'h0A, 32'h1122_CCDD);
        check_hold(1, 32'h1122_CCDD);

        wr(0, 8'h20, 32'h0102_0304, 4'hF);
        apply_stimulus(0, 1'b1, 4'hF, 8'h20, 32'hCAFE_F00D, 1'b1, 8'h20, 1'b0, 1'b1, 32'h0102_0304);
        rd(0, 8'h20, 32'hCAFE_F00D);
        apply_stimulus(0, 1'b1, 4'hF, 8'h21, 32'h7777_7777, 1'b1, 8'h20, 1'b0, 1'b1, 32'hCAFE_F00D);
        wr(1, 8'h02, 32'h0102_0304, 4'h3);
        apply_stimulus(1, 1'b1, 4'h3, 8'h02, 32'hCAFE_F00D, 1'b1, 8'h02, 1'b0, 1'b1, 32'hCAFE_F00D);
        rd(1, 8'h02, 32'hCAFE_F00D);
        apply_stimulus(1, 1'b1, 4'h2, 8'h02, 32'h9999_8888, 1'b1, 8'h02, 1'b0, 1'b1, 32'h9999_F00D);
        rd(1, 8'h02, 32'h9999_F00D);

        wr(0, 8'h05, 32'hDEAD_BEEF, 4'hF);
        wr(1, 8'h05, 32'hDEAD_BEEF, 4'h3);
        rd(0, 8'h05, 32'hDEAD_BEEF);
        rd(1, 8'h05, 32'hDEAD_BEEF);
        pulse_clear(1'b1);
        measure_busy(6, 1'b1, 1'b1, n0, n1);
        check_output("clear_len0", n0, 256);
        check_output("clear_len1", n1, 16);
        rd(0, 8'h05, 32'h0);
        rd(1, 8'h05, CV1);
        rd(0, 8'h10, 32'h0);
        rd(1, 8'h0A, CV1);

        wr(0, 8'h33, 32'h600D_CAFE, 4'hF);
        rd(0, 8'h33, 32'h600D_CAFE);
        wr(1, 8'h03, 32'h600D_CAFE, 4'h3);
        rd(1, 8'h03, 32'h600D_CAFE);
        pulse_clear(1'b0);
        repeat (50) @(negedge clk);
        check_output("busy_hold_data0", bus0.data_out, 32'h600D_CAFE);
        check_output("busy_hold_data1", bus1.data_out, 32'h600D_CAFE);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        measure_busy(-10, 1'b0, 1'b0, n0, n1);
        check_output("resweep_len0", n0, 256);
        check_output("resweep_len1", n1, 16);
        rd(0, 8'h33, 32'h0);
        rd(1, 8'h03, CV1);
        wr(0, 8'h10, 32'h1122_3344, 4'hF);
        wr(0, 8'h10, 32'hAABB_CCDD, 4'b0101);
        rd(0, 8'h10, 32'h11BB_33DD);
        wr(1, 8'h0A, 32'h1122_3344, 4'h3);
        wr(1, 8'h0A, 32'hAABB_CCDD, 4'h1);
        rd(1, 8'h0A, 32'h1122_CCDD);

        repeat (3) @(negedge clk);
        check_output("pending_reads0", q0.size(), 0);
        check_output("pending_reads1", q1.size(), 0);
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
